// File: rtl/nanci_pkg.sv
// rtl/nanci_pkg.sv - shared types and helpers for the Nanci sorting mesh
package nanci_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SORT = 1'b1
    } state_e;

    typedef enum logic {
        PH_ROW = 1'b0,
        PH_COL = 1'b1
    } phase_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mesh_pe_cmpx.sv
// rtl/mesh_pe_cmpx.sv - combinational compare-exchange; returns the key this PE keeps
module mesh_pe_cmpx #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] key_i,
    input  logic [DATA_W-1:0] partner_i,
    input  logic              keep_min_i,
    input  logic              signed_mode_i,
    output logic [DATA_W-1:0] key_o
);

    logic partner_lt;
    logic partner_gt;

    always_comb begin
        if (signed_mode_i) begin
            partner_lt = $signed(partner_i) < $signed(key_i);
            partner_gt = $signed(partner_i) > $signed(key_i);
        end else begin
            partner_lt = partner_i < key_i;
            partner_gt = partner_i > key_i;
        end
    end

    // Strict compares: on a tie both sides keep their own key.
    assign key_o = keep_min_i ? (partner_lt ? partner_i : key_i)
                              : (partner_gt ? partner_i : key_i);

endmodule

// File: rtl/mesh_sort_pe.sv
// rtl/mesh_sort_pe.sv - one processing element of the shearsort mesh
// Runs LOG+1 snake row phases interleaved with LOG column phases in lock-step with its neighbours.
module mesh_sort_pe
    import nanci_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SQRT_N = 4,
    parameter int ROW    = 0,
    parameter int COL    = 0,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_start,
    input  logic              i_descend,
    input  logic [DATA_W-1:0] i_key_l,
    input  logic [DATA_W-1:0] i_key_r,
    input  logic [DATA_W-1:0] i_key_u,
    input  logic [DATA_W-1:0] i_key_d,
    output logic [DATA_W-1:0] o_key,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LOG    = clog2(SQRT_N);
    localparam int NPH    = 2 * LOG + 1;
    localparam int STEP_W = (LOG < 1) ? 1 : LOG;
    localparam int PH_W   = (clog2(NPH) < 1) ? 1 : clog2(NPH);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SQRT_N - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(NPH - 1);

    localparam logic ROW_ODD = (ROW % 2) == 1;
    localparam logic COL_ODD = (COL % 2) == 1;
    localparam logic HAS_R   = COL < SQRT_N - 1;
    localparam logic HAS_L   = COL > 0;
    localparam logic HAS_D   = ROW < SQRT_N - 1;
    localparam logic HAS_U   = ROW > 0;
    localparam logic SGN     = SIGNED != 0;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic                desc_q, desc_d;
    logic                done_q, done_d;

    phase_e              phase_type;
    logic                pair_hi;
    logic                has_partner;
    logic                keep_min;
    logic [DATA_W-1:0]   partner;
    logic [DATA_W-1:0]   cmp_key;

    // Even phase indices are row phases, odd ones column phases.
    always_comb begin
        phase_type  = phase_q[0] ? PH_COL : PH_ROW;
        has_partner = 1'b0;
        keep_min    = 1'b0;
        partner     = key_q;
        if (phase_type == PH_ROW) begin
            pair_hi = (COL_ODD == step_q[0]);
            if (pair_hi && HAS_R) begin
                has_partner = 1'b1;
                partner     = i_key_r;
                keep_min    = 1'b1;
            end else if (!pair_hi && HAS_L) begin
                has_partner = 1'b1;
                partner     = i_key_l;
                keep_min    = 1'b0;
            end
            // Odd rows run right-to-left so the rows form a snake.
            if (ROW_ODD) begin
                keep_min = !keep_min;
            end
        end else begin
            pair_hi = (ROW_ODD == step_q[0]);
            if (pair_hi && HAS_D) begin
                has_partner = 1'b1;
                partner     = i_key_d;
                keep_min    = 1'b1;
            end else if (!pair_hi && HAS_U) begin
                has_partner = 1'b1;
                partner     = i_key_u;
                keep_min    = 1'b0;
            end
        end
        keep_min = keep_min ^ desc_q;
    end

    mesh_pe_cmpx #(
        .DATA_W(DATA_W)
    ) u_cmpx (
        .key_i        (key_q),
        .partner_i    (partner),
        .keep_min_i   (keep_min),
        .signed_mode_i(SGN),
        .key_o        (cmp_key)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        key_d   = key_q;
        desc_d  = desc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load_valid) begin
                    key_d = i_load_data;
                end
                if (i_start) begin
                    state_d = SORT;
                    desc_d  = i_descend;
                    step_d  = '0;
                    phase_d = '0;
                end
            end
            SORT: begin
                if (has_partner) begin
                    key_d = cmp_key;
                end
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            phase_q <= '0;
            key_q   <= '0;
            desc_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            key_q   <= key_d;
            desc_q  <= desc_d;
            done_q  <= done_d;
        end
    end

    assign o_key  = key_q;
    assign o_busy = (state_q == SORT);
    assign o_done = done_q;

endmodule
